md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//   Multi-cycle multiply/divide sequencer with HI/LO registers for the 5-stage MIPS pipeline.
//   Starts mult/multu/div/divu from the E stage and counts out the fixed operation latency.
//   Owns HI/LO, serves mfhi/mflo in E and raises the D-stage stall for md-class instructions while busy.
//   Sits beside the ALU in E. md_out joins the E-stage result path. stall_md is OR-ed into the hazard stall.
// PARAMETERS
//   MULT_CYCLES  5   E-stage-inclusive busy length for mult/multu (>=1)
//   DIV_CYCLES   10  E-stage-inclusive busy length for div/divu (>=1)
// PORTS
//   clk       in   1   clock, all state updates on rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   ir_d      in   32  instruction in D stage (stall detection)
//   ir_e      in   32  instruction in E stage (start / move / read decode)
//   rs_e      in   32  forwarded rs operand in E
//   rt_e      in   32  forwarded rt operand in E
//   hi_o      out  32  architectural HI register
//   lo_o      out  32  architectural LO register
//   md_out    out  32  mfhi in E -> hi_o, mflo in E -> lo_o, else 0
//   busy      out  1   unit occupied (start cycle or BUSY state)
//   stall_md  out  1   freeze F/D and bubble E
// BEHAVIOUR
//   Decode: SPECIAL (op 000000) with these funct codes:
//     mult 011000, multu 011001, div 011010, divu 011011
//     mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
//   Reset (async, rst_n=0): state=IDLE, cnt=0, hi_o=0, lo_o=0, staged result=0, busy=0, stall_md=0.
//     Reset mid-operation abandons the op; HI/LO read 0.
//   States: IDLE, BUSY. cnt is 4 bits, sized for max(MULT_CYCLES,DIV_CYCLES).
//   IDLE + start op in ir_e, at the clock edge:
//     latch the 64-bit result {HI,LO}; cnt<=N-1; state<=BUSY.
//     If N==1, commit HI/LO at that same edge and stay IDLE.
//   BUSY, each edge: cnt<=cnt-1. At the edge where cnt==1, commit the staged HI/LO and go to IDLE.
//   Net effect: busy is high for exactly N cycles counting the E cycle.
//     New HI/LO are visible from cycle N after E.
//   busy = (state==BUSY) | (start op in ir_e), combinational.
//   stall_md = busy & (ir_d is any of the 8 md-class instructions).
//     The pipeline guarantees that no md op reaches E while busy.
//   mthi/mtlo in E while IDLE write rs_e into HI/LO at the edge. No busy.
//   If any md op appears in E while BUSY, it is ignored and the simulation assertion fires.
//   Arithmetic:
//     mult: signed 32x32->64.  multu: unsigned 32x32->64.  HI = upper 32 bits, LO = lower 32 bits.
//     div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
//     Divisor zero (all divides): HI = rs_e, LO = 32'hFFFF_FFFF.
//     div 32'h8000_0000 / -1: LO = 32'h8000_0000, HI = 0.
//   md_out is combinational from the current hi_o/lo_o. A read stalled in D always sees committed values.
// STRUCTURE
//   md_pkg holds: funct constants (FN_MULT..FN_MTLO), OP_SPECIAL, state encoding (ST_IDLE, ST_BUSY),
//     and default cycle counts.
//   One sub-module, md_arith: combinational {hi,lo} = f(op[1:0], rs, rt) covering all four ops and both
//     divide corner cases.
//   md_unit_ctrl keeps the FSM, counter, staging register, HI/LO and the stall/read logic.
// TESTING
//   1. mult rs=-3 rt=5 -> busy for cycles 0..4, hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFF1 from cycle 5.
//   2. divu 7/2 -> busy for 10 cycles, then lo_o=3, hi_o=1. div -7/2 -> lo_o=32'hFFFF_FFFD, hi_o=32'hFFFF_FFFF.
//   3. mult in E with mflo in D -> stall_md=1 for exactly 5 cycles. On release, md_out equals the new lo_o.
//   4. div 32'h1234/0 -> hi_o=32'h1234, lo_o=32'hFFFF_FFFF. div 32'h8000_0000/-1 -> lo_o=32'h8000_0000, hi_o=0.
//   5. mthi rs=32'hDEAD_BEEF while IDLE -> hi_o updates at the next edge, busy stays 0, lo_o unchanged.
//   6. rst_n pulled low at cycle 3 of a div -> outputs 0 immediately, state=IDLE. After release, a new
//      mult completes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared decode constants, state encoding and default latencies for the
// multiply/divide unit that sits beside the ALU in the E stage.
package md_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Low two funct bits of the start ops select the arithmetic.
  typedef enum logic [1:0] {
    OPS_MULT  = 2'b00,
    OPS_MULTU = 2'b01,
    OPS_DIV   = 2'b10,
    OPS_DIVU  = 2'b11
  } md_op_e;

  function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) &&
           (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO ||
            fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide producing {hi, lo}, including the
// divide-by-zero and signed-overflow corner cases.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] safe_rt;
  logic [31:0] quot_u, rem_u;
  logic [31:0] rs_mag, rt_mag;
  logic [31:0] quot_m, rem_m;
  logic [31:0] quot_s, rem_s;

  assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  assign div_zero = (rt_i == 32'd0);
  assign div_ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
  // Keep the dividers well-defined when the divisor is zero; result is overridden.
  assign safe_rt  = div_zero ? 32'd1 : rt_i;

  assign quot_u = rs_i / safe_rt;
  assign rem_u  = rs_i % safe_rt;

  // Signed divide on magnitudes: quotient sign from XOR, remainder follows dividend.
  assign rs_mag = rs_i[31]    ? (~rs_i + 32'd1)    : rs_i;
  assign rt_mag = safe_rt[31] ? (~safe_rt + 32'd1) : safe_rt;
  assign quot_m = rs_mag / rt_mag;
  assign rem_m  = rs_mag % rt_mag;
  assign quot_s = (rs_i[31] ^ safe_rt[31]) ? (~quot_m + 32'd1) : quot_m;
  assign rem_s  = rs_i[31] ? (~rem_m + 32'd1) : rem_m;

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      OPS_MULT:  {hi_o, lo_o} = prod_s;
      OPS_MULTU: {hi_o, lo_o} = prod_u;
      OPS_DIV: begin
        if (div_zero) begin
          hi_o = rs_i;
          lo_o = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          hi_o = 32'd0;
          lo_o = 32'h8000_0000;
        end else begin
          hi_o = rem_s;
          lo_o = quot_s;
        end
      end
      OPS_DIVU: begin
        if (div_zero) begin
          hi_o = rs_i;
          lo_o = 32'hFFFF_FFFF;
        end else begin
          hi_o = rem_u;
          lo_o = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO: starts ops from E, counts out
// the fixed latency, serves mfhi/mflo and stalls md-class instructions in D.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        stall_md,
  output md_state_e   state_o
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [5:0]       fn_e;
  logic             special_e;
  logic             start_e, mthi_e, mtlo_e, mfhi_e, mflo_e;
  logic             md_e, md_d;
  logic [CNT_W-1:0] n_start;
  logic [31:0]      arith_hi, arith_lo;
  logic             unused_ir;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      stage_q;
  logic [31:0]      hi_q, lo_q;

  assign fn_e      = ir_e[5:0];
  assign special_e = (ir_e[31:26] == OP_SPECIAL);
  assign start_e   = special_e && (fn_e[5:2] == 4'b0110);
  assign mthi_e    = special_e && (fn_e == FN_MTHI);
  assign mtlo_e    = special_e && (fn_e == FN_MTLO);
  assign mfhi_e    = special_e && (fn_e == FN_MFHI);
  assign mflo_e    = special_e && (fn_e == FN_MFLO);
  assign md_e      = is_md(ir_e[31:26], ir_e[5:0]);
  assign md_d      = is_md(ir_d[31:26], ir_d[5:0]);
  assign n_start   = fn_e[1] ? DIV_N : MULT_N;
  assign unused_ir = ^{ir_d[25:6], ir_e[25:6]};

  md_arith u_arith (
    .op_i (md_op_e'(fn_e[1:0])),
    .rs_i (rs_e),
    .rt_i (rt_e),
    .hi_o (arith_hi),
    .lo_o (arith_lo)
  );

  // Result is computed in the E cycle and held in stage_q until the count expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_e) begin
            stage_q <= {arith_hi, arith_lo};
            if (n_start == CNT_W'(1)) begin
              hi_q  <= arith_hi;
              lo_q  <= arith_lo;
              cnt_q <= '0;
            end else begin
              cnt_q   <= n_start - CNT_W'(1);
              state_q <= ST_BUSY;
            end
          end else if (mthi_e) begin
            hi_q <= rs_e;
          end else if (mtlo_e) begin
            lo_q <= rs_e;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= stage_q[63:32];
            lo_q    <= stage_q[31:0];
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign state_o  = state_q;
  assign busy     = (state_q == ST_BUSY) || start_e;
  assign stall_md = busy && md_d;
  assign md_out   = mfhi_e ? hi_q : (mflo_e ? lo_q : 32'd0);

  // The pipeline must hold md ops in D while busy; one reaching E is a hazard bug.
  a_no_md_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_BUSY) && md_e));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_md_unit_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_d = '0, ir_e = '0, rs_e = '0, rt_e = '0;
  logic [31:0] hi_o, lo_o, md_out;
  logic        busy, stall_md;
  md_state_e   state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [63:0] exp_q[$];

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .ir_d(ir_d), .ir_e(ir_e), .rs_e(rs_e), .rt_e(rt_e),
    .hi_o(hi_o), .lo_o(lo_o), .md_out(md_out), .busy(busy), .stall_md(stall_md),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'b000000, mid, fn};
  endfunction

  function automatic bit ref_is_md(input logic [31:0] ir);
    logic [5:0] fn;
    fn = ir[5:0];
    if (ir[31:26] != 6'b000000) return 1'b0;
    return fn == 6'b011000 || fn == 6'b011001 || fn == 6'b011010 || fn == 6'b011011 ||
           fn == 6'b010000 || fn == 6'b010001 || fn == 6'b010010 || fn == 6'b010011;
  endfunction

  // Reference arithmetic straight from the ISA rules, using 64-bit integers.
  function automatic logic [63:0] ref_calc(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, rm, p;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    if ((fn == FN_DIV || fn == FN_DIVU) && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (fn)
      FN_MULT: begin p = sa * sb; return 64'(p); end
      FN_MULTU: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
      FN_DIV: begin
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic logic [31:0] pick_d();
    case ($urandom_range(0, 3))
      0: return mk_r(FN_MFLO);
      1: return mk_r(FN_MTHI);
      2: return {6'b001000, 20'($urandom), FN_MULT};
      default: return mk_r(6'b100000);
    endcase
  endfunction

  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input bit use_fixed, input logic [31:0] d_fixed);
    int n;
    logic [63:0] res;
    n = (fn == FN_MULT || fn == FN_MULTU) ? MC : DC;
    exp_q.push_back(ref_calc(fn, a, b));
    for (int c = 0; c < n; c++) begin
      ir_e = (c == 0) ? mk_r(fn) : 32'd0;
      rs_e = (c == 0) ? a : $urandom;
      rt_e = (c == 0) ? b : $urandom;
      ir_d = use_fixed ? d_fixed : pick_d();
      #2;
      chk("busy_during_op", 32'(busy), 32'd1);
      chk("stall_during_op", 32'(stall_md), 32'(ref_is_md(ir_d)));
      if (c == 0) chk("md_out_on_start", md_out, 32'd0);
      if (c == 1) chk("state_busy", 32'(state_o), 32'(ST_BUSY));
      if (c == n - 1) begin
        chk("hi_before_commit", hi_o, exp_hi);
        chk("lo_before_commit", lo_o, exp_lo);
      end
      tick();
    end
    res = exp_q.pop_front();
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    ir_e = 32'd0;
    ir_d = use_fixed ? d_fixed : pick_d();
    #2;
    chk("busy_after_op", 32'(busy), 32'd0);
    chk("stall_after_op", 32'(stall_md), 32'd0);
    chk("hi_commit", hi_o, exp_hi);
    chk("lo_commit", lo_o, exp_lo);
    chk("state_idle", 32'(state_o), 32'(ST_IDLE));
    tick();
  endtask

  task automatic move(input logic [5:0] fn, input logic [31:0] v);
    ir_e = mk_r(fn);
    rs_e = v;
    rt_e = $urandom;
    ir_d = pick_d();
    #2;
    chk("move_busy", 32'(busy), 32'd0);
    chk("move_stall", 32'(stall_md), 32'd0);
    tick();
    if (fn == FN_MTHI) exp_hi = v;
    else exp_lo = v;
    ir_e = 32'd0;
    #2;
    chk("move_hi", hi_o, exp_hi);
    chk("move_lo", lo_o, exp_lo);
    tick();
  endtask

  task automatic rd(input logic [5:0] fn);
    ir_e = mk_r(fn);
    ir_d = pick_d();
    #2;
    chk("md_out_read", md_out, (fn == FN_MFHI) ? exp_hi : exp_lo);
    chk("read_busy", 32'(busy), 32'd0);
    tick();
    ir_e = {6'b001000, 20'($urandom), fn};
    #2;
    chk("md_out_non_special", md_out, 32'd0);
    tick();
  endtask

  initial begin
    logic [5:0] fns[4];
    logic [5:0] fn;
    logic [31:0] a, b;
    fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;

    // Reset state
    #3;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_md), 32'd0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    #5 rst_n = 1'b1;
    tick();

    // mult -3 * 5
    run_op(FN_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'd0);
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_o, 32'hFFFF_FFF1);

    // divu 7/2 and div -7/2
    run_op(FN_DIVU, 32'd7, 32'd2, 1'b0, 32'd0);
    chk("divu_lo_const", lo_o, 32'd3);
    chk("divu_hi_const", hi_o, 32'd1);
    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
    chk("div_lo_const", lo_o, 32'hFFFF_FFFD);
    chk("div_hi_const", hi_o, 32'hFFFF_FFFF);

    // mult with mflo held in D: stall for the whole op, then read the new LO
    run_op(FN_MULT, 32'd1234, 32'd5678, 1'b1, mk_r(FN_MFLO));
    ir_d = 32'd0;
    rd(FN_MFLO);
    chk("mflo_new_const", lo_o, 32'd7006652);

    // Divide corner cases
    run_op(FN_DIV, 32'h0000_1234, 32'd0, 1'b0, 32'd0);
    chk("div0_hi_const", hi_o, 32'h0000_1234);
    chk("div0_lo_const", lo_o, 32'hFFFF_FFFF);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
    chk("ovf_lo_const", lo_o, 32'h8000_0000);
    chk("ovf_hi_const", hi_o, 32'd0);

    // mthi while idle
    move(FN_MTHI, 32'hDEAD_BEEF);
    chk("mthi_hi_const", hi_o, 32'hDEAD_BEEF);
    rd(FN_MFHI);

    // Reset in the middle of a div
    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    ir_e = mk_r(FN_DIV);
    rs_e = 32'd100;
    rt_e = 32'd7;
    tick();
    ir_e = 32'd0;
    tick();
    tick();
    ir_d = mk_r(FN_MFHI);
    #2;
    rst_n = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    exp_q.delete();
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall_md), 32'd0);
    chk("midrst_state", 32'(state_o), 32'(ST_IDLE));
    tick();
    #2 rst_n = 1'b1;
    run_op(FN_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0);
    chk("postrst_hi_const", hi_o, 32'd1);
    chk("postrst_lo_const", lo_o, 32'd0);

    // Random mix of ops, moves and reads
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          fn = fns[$urandom_range(0, 3)];
          a = $urandom;
          b = $urandom;
          case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            default: ;
          endcase
          run_op(fn, a, b, 1'b0, 32'd0);
        end
        6, 7: move(($urandom_range(0, 1) == 0) ? FN_MTHI : FN_MTLO, $urandom);
        default: rd(($urandom_range(0, 1) == 0) ? FN_MFHI : FN_MFLO);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
